// File: rtl/sp1_pipe_reg_pkg.sv
// Shared constants for the sp1_pipe_reg slice: state encodings, default width
// and the state-to-occupancy decode.
package sp1_pipe_reg_pkg;

    localparam int unsigned SP1_DW_DEFAULT = 32;

    localparam logic [1:0] SP1_PR_EMPTY = 2'd0;
    localparam logic [1:0] SP1_PR_ONE   = 2'd1;
    localparam logic [1:0] SP1_PR_TWO   = 2'd2;

    // Number of words held in a given state.
    function automatic logic [1:0] occupancy(input logic [1:0] st);
        logic [1:0] n;
        case (st)
            SP1_PR_ONE: n = 2'd1;
            SP1_PR_TWO: n = 2'd2;
            default:    n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sp1_ff.sv
// Enabled DW-bit register with synchronous active-high clear.
module sp1_ff #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sp1_pipe_reg.sv
// Two-entry valid/ready skid slice feeding an sp1_ff bank; every output is a flop.
// Optional X checking on in_valid/out_ready is built with SP1_PIPE_REG_XCHK_EN.
module sp1_pipe_reg
    import sp1_pipe_reg_pkg::*;
#(
    parameter int unsigned DW = SP1_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    cnt
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          accept_c;
    logic          deliver_c;
    logic          main_en;
    logic          skid_en;
    logic [DW-1:0] main_d;
    logic [DW-1:0] skid_q;

`ifdef SP1_PIPE_REG_XCHK_EN
    // An unknown in_valid must never count as an accept.
    assign accept_c = in_ready & (in_valid === 1'b1);
`else
    assign accept_c = in_valid & in_ready;
`endif
    assign deliver_c = out_valid & out_ready;

    // Next state and entry write enables.
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = in_data;
        case (state)
            SP1_PR_EMPTY: begin
                if (accept_c) begin
                    state_nxt = SP1_PR_ONE;
                    main_en   = 1'b1;
                end
            end
            SP1_PR_ONE: begin
                if (accept_c && deliver_c) begin
                    main_en = 1'b1;
                end else if (accept_c) begin
                    state_nxt = SP1_PR_TWO;
                    skid_en   = 1'b1;
                end else if (deliver_c) begin
                    state_nxt = SP1_PR_EMPTY;
                end
            end
            SP1_PR_TWO: begin
                if (deliver_c) begin
                    state_nxt = SP1_PR_ONE;
                    main_en   = 1'b1;
                    main_d    = skid_q;
                end
            end
            default: begin
                state_nxt = SP1_PR_EMPTY;
            end
        endcase
    end

    // State plus status flags decoded from the next state, so they stay flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SP1_PR_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            cnt       <= 2'd0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != SP1_PR_EMPTY);
            in_ready  <= (state_nxt != SP1_PR_TWO);
            cnt       <= occupancy(state_nxt);
        end
    end

    sp1_ff #(.DW(DW)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    sp1_ff #(.DW(DW)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

`ifdef SP1_PIPE_REG_XCHK_EN
    logic xerr;

    // Sticky X detector on the handshake inputs; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            xerr <= 1'b0;
        end else begin
            if ($isunknown(in_valid)) begin
                $display("sp1_pipe_reg : %0t: X on in_valid", $time);
                xerr <= 1'b1;
            end
            if ($isunknown(out_ready)) begin
                $display("sp1_pipe_reg : %0t: X on out_ready", $time);
                xerr <= 1'b1;
            end
        end
    end
`endif

endmodule
